dafa_ctrl: RTL and testbench

DAFA_CTRL -- requirements
Module: dafa_ctrl

---
 rtl/dafa_ctrl.sv | 157 +++++++++++++++
 tb/tb_dafa_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dafa_ctrl.sv
// dafa_ctrl -- sequencer for an external combinational reversible adder.
//
// A command loads (s, x, y, ovf) into operand registers together with a pass
// count. Each RUN cycle the registers drive the adder, and the adder's sum,
// control and overflow results are written back on the next edge. x passes
// through the adder unchanged, so it is simply held. After cmd_cnt passes, or
// immediately when cmd_cnt is 0, the result is presented with a valid/ready
// handshake.
//
// Optional feature: define DAFA_CTRL_ABORT_EN to add the abort input and the
// rsp_aborted output. abort cuts a run short without capturing the adder
// results on that edge.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_s/x/y, cmd_ovf, cmd_cnt    initial operands and pass count
//   dp_s/x/y, dp_ovf               operands driven to the adder
//   dp_s_ret/dp_y_ret/dp_ovf_ret   adder results
//   rsp_valid/rsp_ready            response handshake
//   rsp_s/rsp_y/rsp_ovf            final values; they mirror the registers
//                                  at all times
//   busy                           high whenever the controller is not idle
//   abort, rsp_aborted             present only with DAFA_CTRL_ABORT_EN
module dafa_ctrl #(
    parameter int W  = 12,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [W-1:0]  cmd_s,
    input  logic [W-1:0]  cmd_x,
    input  logic [W-1:0]  cmd_y,
    input  logic          cmd_ovf,
    input  logic [CW-1:0] cmd_cnt,
    output logic [W-1:0]  dp_s,
    output logic [W-1:0]  dp_x,
    output logic [W-1:0]  dp_y,
    output logic          dp_ovf,
    input  logic [W-1:0]  dp_s_ret,
    input  logic [W-1:0]  dp_y_ret,
    input  logic          dp_ovf_ret,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [W-1:0]  rsp_s,
    output logic [W-1:0]  rsp_y,
    output logic          rsp_ovf,
`ifdef DAFA_CTRL_ABORT_EN
    input  logic          abort,
    output logic          rsp_aborted,
`endif
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  s_reg, x_reg, y_reg;
    logic          ovf_reg;
    logic [CW-1:0] rem;
    logic          accept;
    logic          abort_run;

`ifdef DAFA_CTRL_ABORT_EN
    logic aborted_reg;
    assign abort_run   = (state == RUN) && abort;
    assign rsp_aborted = aborted_reg;
`else
    assign abort_run = 1'b0;
`endif

    assign accept = (state == IDLE) && cmd_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid)
                    state_nxt = (cmd_cnt != '0) ? RUN : DONE;
            end
            RUN: begin
                // The pass counter is compared, not tested for zero after
                // the decrement, so the edge that consumes the last pass is
                // also the edge that leaves RUN.
                if (abort_run || rem == CW'(1))
                    state_nxt = DONE;
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_reg   <= '0;
            x_reg   <= '0;
            y_reg   <= '0;
            ovf_reg <= 1'b0;
            rem     <= '0;
`ifdef DAFA_CTRL_ABORT_EN
            aborted_reg <= 1'b0;
`endif
        end else if (accept) begin
            s_reg   <= cmd_s;
            x_reg   <= cmd_x;
            y_reg   <= cmd_y;
            ovf_reg <= cmd_ovf;
            rem     <= cmd_cnt;
`ifdef DAFA_CTRL_ABORT_EN
            aborted_reg <= 1'b0;
`endif
        end else if (state == RUN) begin
            if (abort_run) begin
                // The in-flight adder results are dropped on purpose, so the
                // response shows the state after the last completed pass.
`ifdef DAFA_CTRL_ABORT_EN
                aborted_reg <= 1'b1;
`endif
            end else begin
                s_reg   <= dp_s_ret;
                y_reg   <= dp_y_ret;
                ovf_reg <= dp_ovf_ret;
                rem     <= rem - CW'(1);
            end
        end
    end

    assign dp_s   = s_reg;
    assign dp_x   = x_reg;
    assign dp_y   = y_reg;
    assign dp_ovf = ovf_reg;

    assign rsp_s   = s_reg;
    assign rsp_y   = y_reg;
    assign rsp_ovf = ovf_reg;

endmodule

// File: tb/tb_dafa_ctrl.sv
module tb_dafa_ctrl;
    localparam int W  = 12;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready;
    logic [W-1:0]  cmd_s, cmd_x, cmd_y;
    logic          cmd_ovf;
    logic [CW-1:0] cmd_cnt;
    logic [W-1:0]  dp_s, dp_x, dp_y;
    logic          dp_ovf;
    logic [W-1:0]  dp_s_ret, dp_y_ret;
    logic          dp_ovf_ret;
    logic          rsp_valid, rsp_ready;
    logic [W-1:0]  rsp_s, rsp_y;
    logic          rsp_ovf;
    logic          busy;
`ifdef DAFA_CTRL_ABORT_EN
    logic          abort;
    logic          rsp_aborted;
`endif

    int total  = 0;
    int passed = 0;
    int n;

    always #5 clk = ~clk;

    // Adder stub: sum = s + x with carry folded into the overflow line.
    logic [W:0] sum_full;
    always_comb begin
        sum_full   = {1'b0, dp_s} + {1'b0, dp_x};
        dp_s_ret   = sum_full[W-1:0];
        dp_y_ret   = dp_y;
        dp_ovf_ret = dp_ovf ^ sum_full[W];
    end

    dafa_ctrl #(.W(W), .CW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_s      (cmd_s),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .cmd_ovf    (cmd_ovf),
        .cmd_cnt    (cmd_cnt),
        .dp_s       (dp_s),
        .dp_x       (dp_x),
        .dp_y       (dp_y),
        .dp_ovf     (dp_ovf),
        .dp_s_ret   (dp_s_ret),
        .dp_y_ret   (dp_y_ret),
        .dp_ovf_ret (dp_ovf_ret),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_s      (rsp_s),
        .rsp_y      (rsp_y),
        .rsp_ovf    (rsp_ovf),
`ifdef DAFA_CTRL_ABORT_EN
        .abort      (abort),
        .rsp_aborted(rsp_aborted),
`endif
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [W-1:0] s, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic ovf,
                         input logic [CW-1:0] cnt);
        cmd_s = s; cmd_x = x; cmd_y = y; cmd_ovf = ovf; cmd_cnt = cnt;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    // Edges after acceptance until rsp_valid, bounded.
    task automatic wait_rsp(output int edges);
        edges = 0;
        while (rsp_valid !== 1'b1 && edges < 40) begin
            step();
            edges++;
        end
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_s = '0; cmd_x = '0; cmd_y = '0; cmd_ovf = 1'b0; cmd_cnt = '0;
`ifdef DAFA_CTRL_ABORT_EN
        abort = 1'b0;
`endif
        #3;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_rsp_s",     32'(rsp_s),     32'd0);
        chk("rst_dp_s",      32'(dp_s),      32'd0);
        #9 rst_n = 1'b1;
        step();

        // 4 passes of +5 starting from 0.
        issue(12'h000, 12'h005, 12'h003, 1'b0, 4'd4);
        chk("run_busy",      32'(busy),      32'd1);
        chk("run_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("run_rsp_valid", 32'(rsp_valid), 32'd0);
        wait_rsp(n);
        chk("lat4",          32'(n),         32'd4);
        chk("sum20_s",       32'(rsp_s),     32'd20);
        chk("sum20_y",       32'(rsp_y),     32'd3);
        chk("sum20_ovf",     32'(rsp_ovf),   32'd0);
        release_rsp();
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("idle_busy",      32'(busy),      32'd0);
        chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);

        // Wraparound sets overflow.
        issue(12'hFFF, 12'h001, 12'h000, 1'b0, 4'd1);
        wait_rsp(n);
        chk("lat1",     32'(n),       32'd1);
        chk("wrap_s",   32'(rsp_s),   32'h000);
        chk("wrap_ovf", 32'(rsp_ovf), 32'd1);
        release_rsp();

        // Zero passes: response in the cycle after accept, held under backpressure.
        issue(12'h123, 12'h001, 12'h000, 1'b0, 4'd0);
        chk("cnt0_valid", 32'(rsp_valid), 32'd1);
        chk("cnt0_s",     32'(rsp_s),     32'h123);
        cmd_s = 12'h456; cmd_cnt = 4'd0; cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_valid",     32'(rsp_valid), 32'd1);
            chk("hold_s",         32'(rsp_s),     32'h123);
            chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        cmd_valid = 1'b0;
        release_rsp();
        chk("after_hold_ready", 32'(cmd_ready), 32'd1);

        // Maximum pass count.
        issue(12'h000, 12'h001, 12'h000, 1'b0, 4'd15);
        wait_rsp(n);
        chk("lat15",  32'(n),     32'd15);
        chk("max_s",  32'(rsp_s), 32'd15);
        release_rsp();

        // Asynchronous reset in the middle of a run.
        issue(12'h000, 12'h001, 12'h000, 1'b0, 4'd8);
        step(); step(); step();
        chk("mid_s", 32'(dp_s), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("arst_busy",      32'(busy),      32'd0);
        chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("arst_rsp_s",     32'(rsp_s),     32'd0);
        chk("arst_dp_x",      32'(dp_x),      32'd0);
        #2 rst_n = 1'b1;
        cmd_s = 12'h010; cmd_x = 12'h003; cmd_y = 12'h007; cmd_ovf = 1'b1; cmd_cnt = 4'd2;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk("post_rst_busy", 32'(busy), 32'd1);
        wait_rsp(n);
        chk("post_rst_lat", 32'(n),       32'd2);
        chk("post_rst_s",   32'(rsp_s),   32'h016);
        chk("post_rst_y",   32'(rsp_y),   32'h007);
        chk("post_rst_ovf", 32'(rsp_ovf), 32'd1);
        release_rsp();

`ifdef DAFA_CTRL_ABORT_EN
        issue(12'h000, 12'h002, 12'h000, 1'b0, 4'd8);
        step(); step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_valid", 32'(rsp_valid),   32'd1);
        chk("abort_s",     32'(rsp_s),       32'd4);
        chk("abort_flag",  32'(rsp_aborted), 32'd1);
        release_rsp();
        issue(12'h000, 12'h001, 12'h000, 1'b0, 4'd1);
        chk("abort_clr",   32'(rsp_aborted), 32'd0);
        wait_rsp(n);
        chk("noabort_s",    32'(rsp_s),       32'd1);
        chk("noabort_flag", 32'(rsp_aborted), 32'd0);
        release_rsp();
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
